// File: rtl/pdm_pkg.sv
// Shared PDM/PCM definitions, used by the decimator and reusable by the modulator.
package pdm_pkg;

    localparam int PCM_W = 16;
    localparam logic [PCM_W-1:0] PCM_MID = 16'h8000;

    // Integrator width that holds R^order without ambiguity, plus sign and headroom.
    function automatic int cic_width(input int order, input int dlog2);
        return order * dlog2 + 2;
    endfunction

endpackage

// File: rtl/pdm_decimator_if.sv
// PDM receive bundle: run enable and PDM pins in, PCM sample stream out.
interface pdm_decimator_if;
    import pdm_pkg::*;

    logic             en;
    logic             pdm_in;
    logic             pdm_clk;
    logic [PCM_W-1:0] pcm_out;
    logic             pcm_valid;

    modport master (output en, pdm_in, input pdm_clk, pcm_out, pcm_valid);
    modport slave  (input en, pdm_in, output pdm_clk, pcm_out, pcm_valid);

endinterface

// File: rtl/pdm_clk_gen.sv
// PDM bit-clock divider plus two-flop input synchroniser and sample strobe.
module pdm_clk_gen #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic pdm_in,
    output logic pdm_clk,
    output logic sample_tick,
    output logic sample_bit
);
    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] div_cnt, div_nxt;
    logic          s1, s2;

    always_comb begin
        div_nxt = (div_cnt == DW'(CLK_DIV - 1)) ? '0 : div_cnt + 1'b1;
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values; s1->s2 stays a real 2-stage chain.
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            div_cnt <= '0;
            pdm_clk <= 1'b0;
            s1      <= 1'b0;
            s2      <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            // Registered from the next count so pdm_clk lines up with div_cnt.
            pdm_clk <= (div_nxt >= DW'(CLK_DIV / 2));
            s1      <= pdm_in;
            s2      <= s1;
        end
    end

    // Last cycle of the high phase: the source has had a full half period to settle.
    assign sample_tick = (div_cnt == DW'(CLK_DIV - 1));
    assign sample_bit  = s2;

endmodule

// File: rtl/pdm_decimator.sv
// 1-bit PDM to 16-bit offset-binary PCM: 3rd-order CIC, decimation by 2^DECIM_LOG2.
module pdm_decimator
    import pdm_pkg::*;
#(
    parameter int CLK_DIV    = 8,
    parameter int DECIM_LOG2 = 6,
    parameter int CIC_ORDER  = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    pdm_decimator_if.slave bus
);
    localparam int W = cic_width(CIC_ORDER, DECIM_LOG2);
    localparam logic signed [W-1:0] SAT_MAX = {2'b00, {(W-2){1'b1}}};

    logic                  clear, sample_tick, sample_bit, dec_fire;
    logic [DECIM_LOG2-1:0] dec_cnt;
    logic signed [W-1:0]   x, i1, i2, i3, i1_n, i2_n, i3_n;
    logic signed [W-1:0]   comb_q   [CIC_ORDER];
    logic signed [W-1:0]   dly_q    [CIC_ORDER];
    logic signed [W-1:0]   stage_in [CIC_ORDER];
    logic [CIC_ORDER-1:0]  stage_en, vld_q;
    logic signed [W-1:0]   c_sat;
    logic [PCM_W-1:0]      pcm_q, pcm_next;
    logic                  pcm_valid_q;

    assign clear = !rst_n || !bus.en;

    pdm_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (bus.en),
        .pdm_in      (bus.pdm_in),
        .pdm_clk     (bus.pdm_clk),
        .sample_tick (sample_tick),
        .sample_bit  (sample_bit)
    );

    // Chained integrator update: each stage sees the value its predecessor takes this tick.
    always_comb begin
        x        = sample_bit ? W'(1) : '1;
        i1_n     = i1 + x;
        i2_n     = i2 + i1_n;
        i3_n     = i3 + i2_n;
        dec_fire = sample_tick && (&dec_cnt);
    end

    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        stage_in[0] = i3_n;
        for (int k = 1; k < CIC_ORDER; k++) begin
            stage_in[k] = comb_q[k-1];
        end
        stage_en = {vld_q[CIC_ORDER-2:0], dec_fire};
    end

    // NOTE: comb/delay arrays are cleared explicitly; en=0 must discard the whole pipeline, not just the valids.
    always_ff @(posedge clk) begin
        if (clear) begin
            i1      <= '0;
            i2      <= '0;
            i3      <= '0;
            dec_cnt <= '0;
            vld_q   <= '0;
            for (int k = 0; k < CIC_ORDER; k++) begin
                comb_q[k] <= '0;
                dly_q[k]  <= '0;
            end
        end else begin
            if (sample_tick) begin
                i1      <= i1_n;
                i2      <= i2_n;
                i3      <= i3_n;
                dec_cnt <= dec_cnt + 1'b1;
            end
            vld_q <= stage_en;
            for (int k = 0; k < CIC_ORDER; k++) begin
                if (stage_en[k]) begin
                    comb_q[k] <= stage_in[k] - dly_q[k];
                    dly_q[k]  <= stage_in[k];
                end
            end
        end
    end

    // Full-scale positive (exactly 2^(W-2)) is the only value that would overflow the PCM range.
    always_comb begin
        c_sat = comb_q[CIC_ORDER-1];
        if (!c_sat[W-1] && c_sat[W-2]) begin
            c_sat = SAT_MAX;
        end
        pcm_next = PCM_W'(c_sat >>> (W - 1 - PCM_W)) ^ PCM_MID;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            pcm_q       <= PCM_MID;
            pcm_valid_q <= 1'b0;
        end else begin
            pcm_valid_q <= vld_q[CIC_ORDER-1];
            if (vld_q[CIC_ORDER-1]) begin
                pcm_q <= pcm_next;
            end
        end
    end

    assign bus.pcm_out   = pcm_q;
    assign bus.pcm_valid = pcm_valid_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// Self-checking bench for pdm_decimator: vector table of PDM patterns, scoreboard of expected PCM strobes.
module tb_pdm_decimator;
    import pdm_pkg::*;

    localparam int CLK_DIV = 8;
    localparam int R       = 64;
    localparam int PERIOD  = CLK_DIV * R;
    localparam int LAT     = 4;

    typedef enum int {P_ONE, P_ZERO, P_ALT, P_MOD} pat_e;

    typedef struct {
        pat_e        pat;
        logic [15:0] level;
        bit          glitch;
        int          drop_at;
        int          n_samples;
        logic [15:0] expv;
        int          tol;
    } vec_t;

    typedef struct {
        int          cycle;
        bit          chk;
        logic [15:0] val;
        int          tol;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    pdm_decimator_if bus();

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    vec_t vecs[5];

    always #5 clk = ~clk;

    pdm_decimator #(.CLK_DIV(CLK_DIV), .DECIM_LOG2(6), .CIC_ORDER(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic apply_reset(input int vi);
        @(negedge clk);
        rst_n = 1'b0;
        bus.en = 1'b1;
        repeat (5) begin
            @(negedge clk);
            bus.pdm_in = ~bus.pdm_in;
        end
        check($sformatf("v%0d_rst_pdm_clk", vi), bus.pdm_clk == 1'b0, bus.pdm_clk, 0);
        check($sformatf("v%0d_rst_valid", vi), bus.pcm_valid == 1'b0, bus.pcm_valid, 0);
        check($sformatf("v%0d_rst_pcm", vi), bus.pcm_out == 16'h8000, bus.pcm_out, 16'h8000);
        rst_n = 1'b1;
    endtask

    // Runs one vector starting at the cycle right after reset release (div_cnt==0 there).
    task automatic run_vector(input int vi, input vec_t v);
        int          c = 0;
        int          limit;
        bit          cur_bit = 1'b0;
        bit          drop_pending = 1'b0;
        logic [16:0] acc = '0;
        int          hold_at = -1;
        logic [15:0] hold_val = '0;
        exp_t        e;
        limit = v.n_samples * PERIOD + 16;
        sb.delete();
        while (c < limit) begin
            if (v.drop_at >= 0 && c == v.drop_at && !drop_pending) begin
                bus.en = 1'b0;
                drop_pending = 1'b1;
            end else if (drop_pending && v.drop_at >= 0) begin
                check($sformatf("v%0d_drop_valid", vi), bus.pcm_valid == 1'b0, bus.pcm_valid, 0);
                check($sformatf("v%0d_drop_pcm", vi), bus.pcm_out == 16'h8000, bus.pcm_out, 16'h8000);
                check($sformatf("v%0d_drop_pdm_clk", vi), bus.pdm_clk == 1'b0, bus.pdm_clk, 0);
                bus.en = 1'b1;
                sb.delete();
                acc = '0;
                hold_at = -1;
                c = 0;
                v.drop_at = -1;
                drop_pending = 1'b0;
            end

            // New bit for tick j=c/8 applied at the start of its period; optional glitch mid low phase.
            if (c % CLK_DIV == 0) begin
                int j = c / CLK_DIV;
                case (v.pat)
                    P_ONE:   cur_bit = 1'b1;
                    P_ZERO:  cur_bit = 1'b0;
                    P_ALT:   cur_bit = (j % 2 == 0);
                    default: begin
                        acc = {1'b0, acc[15:0]} + {1'b0, v.level};
                        cur_bit = acc[16];
                    end
                endcase
                bus.pdm_in = cur_bit;
                if (j % R == R - 1) begin
                    e.cycle = j * CLK_DIV + (CLK_DIV - 1) + LAT;
                    e.chk   = (j / R) >= 3;
                    e.val   = v.expv;
                    e.tol   = v.tol;
                    sb.push_back(e);
                end
            end else if (v.glitch && c % CLK_DIV == 1) begin
                bus.pdm_in = ~cur_bit;
            end else if (v.glitch && c % CLK_DIV == 3) begin
                bus.pdm_in = cur_bit;
            end

            if (c < 2 * CLK_DIV) begin
                check($sformatf("v%0d_phase_c%0d", vi, c), bus.pdm_clk == ((c % CLK_DIV) >= CLK_DIV / 2),
                      bus.pdm_clk, (c % CLK_DIV) >= CLK_DIV / 2);
            end

            if (sb.size() > 0 && sb[0].cycle == c) begin
                e = sb.pop_front();
                check($sformatf("v%0d_valid_at_c%0d", vi, c), bus.pcm_valid == 1'b1, bus.pcm_valid, 1);
                if (e.chk) begin
                    int diff = int'(bus.pcm_out) - int'(e.val);
                    check($sformatf("v%0d_pcm_c%0d", vi, c), diff <= e.tol && diff >= -e.tol, bus.pcm_out, e.val);
                    hold_at = c + 200;
                    hold_val = e.val;
                end
            end else begin
                if (bus.pcm_valid) begin
                    check($sformatf("v%0d_spurious_valid_c%0d", vi, c), bus.pcm_valid == 1'b0, bus.pcm_valid, 0);
                end
            end

            if (c == hold_at) begin
                int diff = int'(bus.pcm_out) - int'(hold_val);
                check($sformatf("v%0d_hold_c%0d", vi, c), diff <= v.tol && diff >= -v.tol, bus.pcm_out, hold_val);
            end

            @(negedge clk);
            c++;
        end
        check($sformatf("v%0d_missing_pulses", vi), sb.size() == 0, sb.size(), 0);
    endtask

    initial begin
        bus.en = 1'b1;
        bus.pdm_in = 1'b0;

        vecs[0] = '{pat: P_ONE,  level: 16'h0000, glitch: 1'b1, drop_at: -1,  n_samples: 6, expv: 16'hFFFF, tol: 0};
        vecs[1] = '{pat: P_ZERO, level: 16'h0000, glitch: 1'b1, drop_at: -1,  n_samples: 6, expv: 16'h0000, tol: 0};
        vecs[2] = '{pat: P_ALT,  level: 16'h0000, glitch: 1'b0, drop_at: -1,  n_samples: 6, expv: 16'h8000, tol: 0};
        vecs[3] = '{pat: P_MOD,  level: 16'hC000, glitch: 1'b0, drop_at: -1,  n_samples: 6, expv: 16'hC000, tol: 64};
        // en dropped during comb stage 2 of the first decimated sample (tick at 511, c2 at 513).
        vecs[4] = '{pat: P_ONE,  level: 16'h0000, glitch: 1'b0, drop_at: 513, n_samples: 5, expv: 16'hFFFF, tol: 0};

        for (int vi = 0; vi < 5; vi++) begin
            apply_reset(vi);
            run_vector(vi, vecs[vi]);
        end

        // Reset asserted mid-pipeline instead of en: the in-flight sample must vanish.
        apply_reset(5);
        bus.pdm_in = 1'b1;
        repeat (PERIOD - 1 + 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_pcm", bus.pcm_out == 16'h8000, bus.pcm_out, 16'h8000);
        begin
            int seen = 0;
            int at = -1;
            for (int c = 0; c < PERIOD + 16; c++) begin
                if (bus.pcm_valid && seen == 0) begin
                    seen = 1;
                    at = c;
                end
                @(negedge clk);
            end
            check("rst_mid_next_valid_cycle", at == PERIOD - 1 + LAT, at, PERIOD - 1 + LAT);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
